// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter, instruction fetch handshake and next-PC
// selection for a non-overlapped (fetch, then execute) MIPS core.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        stall,
    input  logic [2:0]  Branch,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic [31:0] instr_cnt,
    output logic        align_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_capture;
    logic        w_retire;

    logic        r_req;
    logic        r_ivld;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_cnt;
    logic        r_aerr;

    logic [31:0] w_pc4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_jr_tgt;
    logic [31:0] w_pc_nxt;
    logic        w_jr_misalign;

    // Target candidates; the j-target keeps the region bits of pc+4, not pc.
    assign w_pc4         = r_pc + 32'd4;
    assign w_br_tgt      = w_pc4 + {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
    assign w_j_tgt       = {w_pc4[31:28], r_ir[25:0], 2'b00};
    assign w_jr_tgt      = {rs_data[31:2], 2'b00};
    assign w_jr_misalign = (Branch == 3'b111) && (rs_data[1:0] != 2'b00);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; capture/retire strobes mark the two state-advancing edges.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid) begin
                    w_state_nxt = S_EXEC;
                    w_capture   = 1'b1;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    w_state_nxt = S_FETCH;
                    w_retire    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next-PC priority: jr, then j/jal, then taken beq/bne, else sequential.
    always_comb begin
        w_pc_nxt = w_pc4;
        if (Branch == 3'b111) begin
            w_pc_nxt = w_jr_tgt;
        end else if (jump || (Branch == 3'b011)) begin
            w_pc_nxt = w_j_tgt;
        end else if ((Branch == 3'b010) && zero) begin
            w_pc_nxt = w_br_tgt;
        end else if ((Branch == 3'b001) && !zero) begin
            w_pc_nxt = w_br_tgt;
        end
    end

    // Registered decodes of the upcoming state so req/valid are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req  <= 1'b0;
            r_ivld <= 1'b0;
        end else begin
            r_req  <= (w_state_nxt == S_FETCH);
            r_ivld <= (w_state_nxt == S_EXEC);
        end
    end

    // Instruction register loads only on the accepting FETCH edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= 32'd0;
        end else if (w_capture) begin
            r_ir <= imem_rdata;
        end
    end

    // PC, retire counter and sticky alignment flag advance when EXEC retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= {RESET_PC[31:2], 2'b00};
            r_cnt  <= 32'd0;
            r_aerr <= 1'b0;
        end else if (w_retire) begin
            r_pc  <= {w_pc_nxt[31:2], 2'b00};
            r_cnt <= r_cnt + 32'd1;
            if (w_jr_misalign) begin
                r_aerr <= 1'b1;
            end
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr       = r_ir;
    assign opcode      = r_ir[31:26];
    assign funct       = r_ir[5:0];
    assign instr_valid = r_ivld;
    assign pc          = r_pc;
    assign link_addr   = w_pc4;
    assign instr_cnt   = r_cnt;
    assign align_err   = r_aerr;

endmodule
